fetch_pc: RTL and testbench

- Fetch stage of the RV64 in-order pipeline.
- Holds the architectural fetch PC and issues one instruction request at a time on the instruction bus.
- Buffers the returned 32-bit instruction toward decode with a valid/ready handshake.
- Consumes the execute stage's redirect pair (branch, jump). Every asserted redirect is unconditional and squashes in-flight or buffered fetches.

---
 rtl/fetch_pc.sv | 147 ++++++++++++++
 tb/tb_fetch_pc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - RV64 fetch stage: fetch PC, single-outstanding instruction request, decode buffer
module fetch_pc #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_valid,
    input  logic [63:0] branch_target,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [63:0] f_pc,
    output logic [31:0] f_instr,
    output logic        f_misalign
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] pc;
    logic [63:0] pc_nxt;
    logic [63:0] pend;
    logic [63:0] pend_nxt;
    logic        f_valid_nxt;
    logic [63:0] f_pc_nxt;
    logic [31:0] f_instr_nxt;
    logic        f_misalign_nxt;
    logic        aligned;

    assign aligned = (pc[1:0] == 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pend       <= '0;
            f_valid    <= 1'b0;
            f_pc       <= '0;
            f_instr    <= '0;
            f_misalign <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pend       <= pend_nxt;
            f_valid    <= f_valid_nxt;
            f_pc       <= f_pc_nxt;
            f_instr    <= f_instr_nxt;
            f_misalign <= f_misalign_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_nxt       = pend;
        f_valid_nxt    = f_valid;
        f_pc_nxt       = f_pc;
        f_instr_nxt    = f_instr;
        f_misalign_nxt = f_misalign;
        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (branch_valid) begin
                    pc_nxt = branch_target;
                end
            end
            REQ: begin
                if (branch_valid) begin
                    // Nothing outstanding on the bus (completed or never issued): restart cleanly.
                    if (!aligned || iresp_data_ok) begin
                        pc_nxt    = branch_target;
                        state_nxt = IDLE;
                    end else begin
                        pend_nxt  = branch_target;
                        state_nxt = DISCARD;
                    end
                end else if (!aligned) begin
                    f_valid_nxt    = 1'b1;
                    f_pc_nxt       = pc;
                    f_instr_nxt    = '0;
                    f_misalign_nxt = 1'b1;
                    state_nxt      = HOLD;
                end else if (iresp_data_ok) begin
                    f_valid_nxt    = 1'b1;
                    f_pc_nxt       = pc;
                    f_instr_nxt    = iresp_data;
                    f_misalign_nxt = 1'b0;
                    pc_nxt         = pc + 64'd4;
                    state_nxt      = HOLD;
                end
            end
            DISCARD: begin
                if (branch_valid) begin
                    pend_nxt = branch_target;
                end
                if (iresp_data_ok) begin
                    pc_nxt    = branch_valid ? branch_target : pend;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (branch_valid) begin
                    f_valid_nxt = 1'b0;
                    pc_nxt      = branch_target;
                    state_nxt   = REQ;
                end else if (f_ready) begin
                    f_valid_nxt = 1'b0;
                    state_nxt   = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // In DISCARD pc still holds the stale address, so the request stays unchanged until it completes.
    always_comb begin
        ireq_valid = 1'b0;
        ireq_addr  = '0;
        case (state)
            REQ: begin
                if (aligned) begin
                    ireq_valid = 1'b1;
                    ireq_addr  = pc;
                end
            end
            DISCARD: begin
                ireq_valid = 1'b1;
                ireq_addr  = pc;
            end
            default: begin
                ireq_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - directed and randomized checks of fetch_pc against a transaction-level model
module tb_fetch_pc;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk;
    logic        reset;
    logic        branch_valid;
    logic [63:0] branch_target;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        f_valid;
    logic        f_ready;
    logic [63:0] f_pc;
    logic [31:0] f_instr;
    logic        f_misalign;

    int n_cmp;
    int n_bad;

    // Model: next fetch address, one-cycle restart gap, squashed outstanding request, decode buffer.
    logic [63:0] m_pc;
    logic        m_gap;
    logic        m_dead;
    logic [63:0] m_old;
    logic        m_buf;
    logic [63:0] m_bpc;
    logic [31:0] m_binstr;
    logic        m_bmis;

    fetch_pc #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .f_valid       (f_valid),
        .f_ready       (f_ready),
        .f_pc          (f_pc),
        .f_instr       (f_instr),
        .f_misalign    (f_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_gap = 1'b1; m_dead = 1'b0; m_old = '0;
        m_buf = 1'b0; m_bpc = '0; m_binstr = '0; m_bmis = 1'b0;
    endtask

    task automatic model_step(input logic bv, input logic [63:0] bt, input logic dok,
                              input logic [31:0] data, input logic frdy);
        if (m_buf) begin
            if (bv) begin m_buf = 1'b0; m_pc = bt; end
            else if (frdy) m_buf = 1'b0;
        end else if (m_gap) begin
            m_gap = 1'b0;
            if (bv) m_pc = bt;
        end else if (m_dead) begin
            if (bv) m_pc = bt;
            if (dok) begin m_dead = 1'b0; m_gap = 1'b1; end
        end else if (m_pc[1:0] != 2'b00) begin
            if (bv) begin m_pc = bt; m_gap = 1'b1; end
            else begin m_buf = 1'b1; m_bpc = m_pc; m_binstr = '0; m_bmis = 1'b1; end
        end else if (bv) begin
            if (dok) m_gap = 1'b1;
            else begin m_dead = 1'b1; m_old = m_pc; end
            m_pc = bt;
        end else if (dok) begin
            m_buf = 1'b1; m_bpc = m_pc; m_binstr = data; m_bmis = 1'b0;
            m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic check_model();
        logic        e_req;
        logic [63:0] e_addr;
        e_req  = !m_gap && !m_buf && (m_dead || (m_pc[1:0] == 2'b00));
        e_addr = e_req ? (m_dead ? m_old : m_pc) : 64'd0;
        chk("m_ireq_valid", 64'(ireq_valid), 64'(e_req));
        chk("m_ireq_addr", ireq_addr, e_addr);
        chk("m_f_valid", 64'(f_valid), 64'(m_buf));
        if (m_buf) begin
            chk("m_f_pc", f_pc, m_bpc);
            chk("m_f_instr", 64'(f_instr), 64'(m_binstr));
            chk("m_f_misalign", 64'(f_misalign), 64'(m_bmis));
        end
    endtask

    task automatic cycle(input logic bv, input logic [63:0] bt, input logic dok,
                         input logic [31:0] data, input logic frdy);
        branch_valid  = bv;
        branch_target = bt;
        iresp_data_ok = dok;
        iresp_data    = data;
        f_ready       = frdy;
        @(posedge clk);
        model_step(bv, bt, dok, data, frdy);
        #1;
        check_model();
    endtask

    task automatic fetch_one(input logic [63:0] addr, input logic [31:0] data);
        chk("seq_req_valid", 64'(ireq_valid), 64'd1);
        chk("seq_req_addr", ireq_addr, addr);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        chk("seq_req_hold_addr", ireq_addr, addr);
        cycle(1'b0, '0, 1'b1, data, 1'b0);
        chk("seq_f_valid", 64'(f_valid), 64'd1);
        chk("seq_f_pc", f_pc, addr);
        chk("seq_f_instr", 64'(f_instr), 64'(data));
        chk("seq_f_misalign", 64'(f_misalign), 64'd0);
        chk("seq_no_req_in_hold", 64'(ireq_valid), 64'd0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        chk("seq_f_valid_drop", 64'(f_valid), 64'd0);
    endtask

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        int unsigned sel;
        sel = $urandom_range(0, 15);
        t = RST_PC + (64'($urandom_range(0, 255)) << 2);
        if (sel == 0) t = t | 64'd2;
        else if (sel == 1) t = t | 64'd1;
        else if (sel == 2) t = 64'hFFFF_FFFF_FFFF_FFF8;
        return t;
    endfunction

    initial begin
        logic        rbv;
        logic [63:0] rbt;
        logic        rdok;
        logic        rfr;
        logic        req_seen;
        int          bus_age;
        int          bus_lat;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        branch_valid = 1'b0; branch_target = '0;
        iresp_data_ok = 1'b0; iresp_data = '0; f_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ireq_valid", 64'(ireq_valid), 64'd0);
        chk("rst_ireq_addr", ireq_addr, 64'd0);
        chk("rst_f_valid", 64'(f_valid), 64'd0);
        chk("rst_f_pc", f_pc, 64'd0);
        chk("rst_f_instr", 64'(f_instr), 64'd0);
        chk("rst_f_misalign", 64'(f_misalign), 64'd0);
        reset = 1'b1;

        // Sequential fetch from the reset PC.
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        fetch_one(64'h8000_0000, 32'h0000_0013);
        fetch_one(64'h8000_0004, 32'h0010_0093);
        fetch_one(64'h8000_0008, 32'h0020_0113);

        // Redirect in HOLD overrides f_ready.
        cycle(1'b0, '0, 1'b1, 32'h1111_1111, 1'b0);
        chk("hold_f_pc", f_pc, 64'h8000_000C);
        cycle(1'b1, 64'h8000_0100, 1'b0, '0, 1'b1);
        chk("squash_f_valid", 64'(f_valid), 64'd0);
        chk("squash_req_addr", ireq_addr, 64'h8000_0100);

        // Redirects while the bus is outstanding: latest wins, old address held.
        cycle(1'b1, 64'h8000_0200, 1'b0, '0, 1'b0);
        chk("disc_addr0", ireq_addr, 64'h8000_0100);
        cycle(1'b1, 64'h8000_0300, 1'b0, '0, 1'b0);
        chk("disc_addr1", ireq_addr, 64'h8000_0100);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        chk("disc_valid2", 64'(ireq_valid), 64'd1);
        cycle(1'b0, '0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        chk("disc_drop_f_valid", 64'(f_valid), 64'd0);
        chk("disc_gap", 64'(ireq_valid), 64'd0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        chk("disc_new_addr", ireq_addr, 64'h8000_0300);

        // Redirect coincident with data_ok.
        cycle(1'b1, 64'h8000_0400, 1'b1, 32'hBAD0_BAD0, 1'b1);
        chk("coinc_gap", 64'(ireq_valid), 64'd0);
        chk("coinc_f_valid", 64'(f_valid), 64'd0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        chk("coinc_addr", ireq_addr, 64'h8000_0400);

        // Misaligned target.
        cycle(1'b0, '0, 1'b1, 32'h2222_2222, 1'b0);
        cycle(1'b1, 64'h8000_0102, 1'b0, '0, 1'b0);
        chk("mis_no_req", 64'(ireq_valid), 64'd0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        chk("mis_f_valid", 64'(f_valid), 64'd1);
        chk("mis_flag", 64'(f_misalign), 64'd1);
        chk("mis_instr", 64'(f_instr), 64'd0);
        chk("mis_pc", f_pc, 64'h8000_0102);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        chk("mis_stable", f_pc, 64'h8000_0102);
        cycle(1'b1, 64'h8000_0500, 1'b0, '0, 1'b0);
        chk("mis_redirect", ireq_addr, 64'h8000_0500);

        // PC wraps past the top of the address space.
        cycle(1'b0, '0, 1'b1, 32'h3333_3333, 1'b0);
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, '0, 1'b1);
        chk("wrap_req", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1'b0, '0, 1'b1, 32'h4444_4444, 1'b0);
        chk("wrap_f_pc", f_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        chk("wrap_valid", 64'(ireq_valid), 64'd1);
        chk("wrap_addr", ireq_addr, 64'd0);

        // Reset while a squashed request is outstanding.
        cycle(1'b1, 64'h8000_0600, 1'b0, '0, 1'b0);
        chk("pre_rst_disc", 64'(ireq_valid), 64'd1);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst_ireq_valid", 64'(ireq_valid), 64'd0);
        chk("arst_ireq_addr", ireq_addr, 64'd0);
        chk("arst_f_valid", 64'(f_valid), 64'd0);
        chk("arst_f_pc", f_pc, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle(1'b0, '0, 1'b1, 32'h5555_5555, 1'b0);
        chk("late_ok_addr", ireq_addr, RST_PC);
        chk("late_ok_f_valid", 64'(f_valid), 64'd0);

        // Randomized traffic with a variable-latency bus.
        bus_age = 0;
        bus_lat = 1;
        for (int i = 0; i < 3000; i++) begin
            rbv      = ($urandom_range(0, 6) == 0);
            rbt      = rand_target();
            rfr      = ($urandom_range(0, 1) == 1);
            req_seen = ireq_valid;
            rdok     = req_seen && (bus_age >= bus_lat);
            cycle(rbv, rbt, rdok, $urandom, rfr);
            if (rdok) begin
                bus_age = 0;
                bus_lat = $urandom_range(0, 3);
            end else if (req_seen) begin
                bus_age++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
